// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises PS2_CLK/PS2_DAT, deserialises 11-bit frames,
// and emits a scancode byte with valid/error strobes. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 27000,
  parameter int TIMER_W        = 15
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic [7:0] frameData,
  output logic       frameValid,
  output logic       frameError,
  output logic       frameBusy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state, stateNext;
  logic [SYNC_STAGES-1:0] clockSync, dataSync;
  logic                 clockPrev;
  logic                 clockNow, bitIn, fall;
  logic [7:0]           shiftReg, shiftNext;
  logic [2:0]           bitCount, bitCountNext;
  logic [TIMER_W-1:0]   timer;
  logic                 timeout, frameOk;
  logic                 validNext, errorNext;
  logic [7:0]           dataNext;
`ifdef PS2_PARITY_CHECK_EN
  logic                 parityBit, parityNext;
`endif

  assign clockNow = clockSync[SYNC_STAGES-1];
  assign bitIn    = dataSync[SYNC_STAGES-1];
  assign fall     = clockPrev & ~clockNow;
  // A fall on the terminal-count cycle keeps the frame alive.
  assign timeout  = (state != IDLE) && !fall && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign frameOk = bitIn && ((^shiftReg) ^ parityBit);
`else
  assign frameOk = bitIn;
`endif

  always_ff @(posedge clock27 or posedge reset) begin
    if (reset) begin
      clockSync <= '1;
      dataSync  <= '1;
      clockPrev <= 1'b1;
    end else begin
      clockSync <= {clockSync[SYNC_STAGES-2:0], keyboardClock};
      dataSync  <= {dataSync[SYNC_STAGES-2:0], keyboardData};
      clockPrev <= clockNow;
    end
  end

  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    bitCountNext = bitCount;
    validNext    = 1'b0;
    errorNext    = 1'b0;
    dataNext     = frameData;
`ifdef PS2_PARITY_CHECK_EN
    parityNext   = parityBit;
`endif
    unique case (state)
      IDLE: begin
        if (fall && !bitIn) begin
          stateNext    = DATA;
          bitCountNext = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shiftNext    = {bitIn, shiftReg[7:1]};
          bitCountNext = bitCount + 3'd1;
          if (bitCount == 3'd7) stateNext = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          parityNext = bitIn;
`endif
          stateNext  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          stateNext = IDLE;
          if (frameOk) begin
            validNext = 1'b1;
            dataNext  = shiftReg;
          end else begin
            errorNext = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (timeout) begin
      stateNext = IDLE;
      errorNext = 1'b1;
    end
  end

  always_ff @(posedge clock27 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      frameBusy  <= 1'b0;
      shiftReg   <= '0;
      bitCount   <= '0;
      timer      <= '0;
      frameData  <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parityBit  <= 1'b0;
`endif
    end else begin
      state      <= stateNext;
      frameBusy  <= (stateNext != IDLE);
      shiftReg   <= shiftNext;
      bitCount   <= bitCountNext;
      frameData  <= dataNext;
      frameValid <= validNext;
      frameError <= errorNext;
`ifdef PS2_PARITY_CHECK_EN
      parityBit  <= parityNext;
`endif
      if (fall || stateNext == IDLE) timer <= '0;
      else if (timer != '1)          timer <= timer + TIMER_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_ps2_frame_receiver;
  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int TW   = 8;
  localparam int H    = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic clock27 = 1'b0, reset = 1'b1, keyboardClock = 1'b1, keyboardData = 1'b1;
  logic [7:0] frameData;
  logic frameValid, frameError, frameBusy;

  ps2_frame_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .TIMER_W(TW)) dut (
    .clock27(clock27), .reset(reset), .keyboardClock(keyboardClock), .keyboardData(keyboardData),
    .frameData(frameData), .frameValid(frameValid), .frameError(frameError), .frameBusy(frameBusy));

  always #5 clock27 = ~clock27;

  int cyc = 0;
  always @(posedge clock27) cyc <= cyc + 1;

  logic [7:0] validByte[$];
  int validCyc[$];
  int errCyc[$];
  int bothCount = 0;
  always @(negedge clock27) begin
    if (frameValid) begin validByte.push_back(frameData); validCyc.push_back(cyc); end
    if (frameError) errCyc.push_back(cyc);
    if (frameValid && frameError) bothCount++;
  end

  int nAssert = 0, nFail = 0;
  logic [7:0] expBytes[$];
  int expErr = 0;
  logic [7:0] lastGood = 8'h00;
  int lastFall = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock27);
    #1;
  endtask

  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      keyboardData = bits[i];
      waitCycles(H);
      keyboardClock = 1'b0;
      lastFall = cyc;
      waitCycles(H);
      keyboardClock = 1'b1;
    end
  endtask

  // Reference model: a frame is good iff stop==1 and (parity unchecked or total ones odd).
  task automatic sendByte(input logic [7:0] b, input bit parFlip, input bit stopZero);
    bit par, stop, good;
    par  = (~^b) ^ parFlip;
    stop = !stopZero;
    good = stop && (!PARITY_EN || (($countones(b) + par) % 2 == 1));
    sendBits({stop, par, b, 1'b0}, 11);
    if (good) begin expBytes.push_back(b); lastGood = b; end
    else expErr++;
  endtask

  task automatic clearObs();
    validByte.delete(); validCyc.delete(); errCyc.delete();
    expBytes.delete(); expErr = 0;
  endtask

  task automatic checkOutcome(input string tag, input bit checkLat);
    int lastStrobe;
    waitCycles(SYNC + 6);
    chk({tag, "_nvalid"}, validByte.size(), expBytes.size());
    for (int i = 0; i < expBytes.size() && i < validByte.size(); i++)
      chk({tag, "_byte"}, validByte[i], expBytes[i]);
    chk({tag, "_nerror"}, errCyc.size(), expErr);
    chk({tag, "_frameData"}, frameData, lastGood);
    chk({tag, "_busy"}, frameBusy, 0);
    chk({tag, "_both"}, bothCount, 0);
    if (checkLat) begin
      lastStrobe = -1;
      if (validCyc.size() > 0) lastStrobe = validCyc[$];
      if (errCyc.size() > 0 && errCyc[$] > lastStrobe) lastStrobe = errCyc[$];
      chk({tag, "_latency"}, lastStrobe - lastFall, SYNC + 1);
    end
    clearObs();
  endtask

  initial begin
    int delta;
    waitCycles(3);
    chk("rst_data", frameData, 0);
    chk("rst_valid", frameValid, 0);
    chk("rst_error", frameError, 0);
    chk("rst_busy", frameBusy, 0);
    reset = 1'b0;
    waitCycles(4);

    sendByte(8'h1C, 0, 0);
    checkOutcome("t1_1C", 1);

    sendByte(8'hF0, 0, 0);
    sendByte(8'h1C, 0, 0);
    checkOutcome("t2_b2b", 1);

    sendByte(8'h1C, 1, 0);
    checkOutcome("t3_badpar", 1);

    sendByte(8'h5A, 0, 1);
    checkOutcome("t4_badstop", 1);

    sendBits(11'h001, 1);
    checkOutcome("glitch_start", 0);

    // Start plus five data bits, then the PS/2 clock stalls high.
    sendBits({3'b111, 8'h45, 1'b0}, 6);
    waitCycles(4);
    chk("t5_busy_mid", frameBusy, 1);
    waitCycles(TMO + 30);
    delta = (errCyc.size() > 0) ? errCyc[0] - lastFall : -1;
    chk("t5_timeout_window", (delta >= TMO && delta <= TMO + SYNC + 2) ? 1 : 0, 1);
    expErr = 1;
    checkOutcome("t5_timeout", 0);
    sendByte(8'h45, 0, 0);
    checkOutcome("t5_after", 1);

    sendBits({3'b111, 8'h16, 1'b0}, 5);
    waitCycles(2);
    reset = 1'b1;
    #1;
    chk("t6_rst_data", frameData, 0);
    chk("t6_rst_valid", frameValid, 0);
    chk("t6_rst_error", frameError, 0);
    chk("t6_rst_busy", frameBusy, 0);
    waitCycles(3);
    reset = 1'b0;
    lastGood = 8'h00;
    waitCycles(2);
    checkOutcome("t6_nostrobe", 0);
    sendByte(8'h16, 0, 0);
    checkOutcome("t6_after", 1);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      int r;
      b = 8'($urandom);
      r = $urandom_range(0, 3);
      sendByte(b, r == 2, r == 3);
      checkOutcome("rand", 1);
      waitCycles($urandom_range(0, 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
